// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back L1 data cache
// with word-serial line fill and victim write-back to L2.
package dcache_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_operation_size_e;
endpackage

module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int LINE_SIZE  = 16,
  parameter int CACHE_SIZE = 256,
  parameter int WAYS       = 2,
  parameter int XLEN       = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [XLEN-1:0]        pipe_req_address,
  input  memory_operation_size_e pipe_req_size,
  input  memory_operation_e      pipe_req_type,
  input  logic                   pipe_req_valid,
  input  logic [XLEN-1:0]        pipe_word_to_store,
  output logic [XLEN-1:0]        pipe_fetched_word,
  output logic                   pipe_req_fulfilled,
  output logic [XLEN-1:0]        l2_req_address,
  output memory_operation_e      l2_req_type,
  output logic                   l2_req_valid,
  output logic [XLEN-1:0]        l2_word_to_store,
  input  logic [XLEN-1:0]        l2_fetched_word,
  input  logic                   l2_req_fulfilled
);
  localparam int WPL  = LINE_SIZE / 4;
  localparam int SETS = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int OW   = $clog2(LINE_SIZE);
  localparam int IW   = $clog2(SETS);
  localparam int TW   = XLEN - OW - IW;
  localparam int WW   = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int SW   = (SETS > 1) ? IW : 1;
  localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  logic [XLEN-1:0] data_q [WAYS][SETS][WPL];
  logic [TW-1:0]   tag_q [WAYS][SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [VW-1:0]   vptr_q [SETS];

  state_e            state_q, state_d;
  logic [WW-1:0]     word_q, word_d;
  logic [VW-1:0]     vway_q, vway_d;
  logic [TW-1:0]     mtag_q, mtag_d;
  logic [SW-1:0]     midx_q, midx_d;
  logic [XLEN-1:0]   l2_addr_q, l2_addr_d;
  memory_operation_e l2_type_q, l2_type_d;
  logic              l2_valid_q, l2_valid_d;
  logic [XLEN-1:0]   l2_wdata_q, l2_wdata_d;

  logic [TW-1:0] req_tag;
  logic [SW-1:0] req_idx;
  logic [WW-1:0] req_wsel;
  assign req_tag  = pipe_req_address[XLEN-1 -: TW];
  assign req_idx  = SW'(pipe_req_address >> OW) & SW'(SETS - 1);
  assign req_wsel = WW'(pipe_req_address >> 2) & WW'(WPL - 1);

  function automatic logic [XLEN-1:0] mk(
    input logic [TW-1:0] t,
    input logic [SW-1:0] i,
    input logic [WW-1:0] w
  );
    return (XLEN'(t) << (OW + IW)) | (XLEN'(i) << OW) | (XLEN'(w) << 2);
  endfunction

  logic          hit;
  logic [VW-1:0] hway, vsel;
  always_comb begin
    hit  = 1'b0;
    hway = '0;
    vsel = vptr_q[req_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
        hit  = 1'b1;
        hway = VW'(w);
      end
    end
    // descending scan so the lowest invalid way wins
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) vsel = VW'(w);
    end
  end

  logic            vdirty;
  logic [XLEN-1:0] hit_word, shifted, ld_data, st_data, st_mask;
  logic [4:0]      sh;
  logic [3:0]      bmask;
  assign vdirty   = valid_q[req_idx][vsel] && dirty_q[req_idx][vsel];
  assign hit_word = data_q[hway][req_idx][req_wsel];

  always_comb begin
    sh    = 5'd0;
    bmask = 4'b1111;
    unique case (pipe_req_size)
      BYTE: begin
        sh    = {pipe_req_address[1:0], 3'b000};
        bmask = 4'b0001 << pipe_req_address[1:0];
      end
      HALF: begin
        sh    = {pipe_req_address[1], 4'b0000};
        bmask = pipe_req_address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    shifted = hit_word >> sh;
    unique case (pipe_req_size)
      BYTE:    ld_data = XLEN'(shifted[7:0]);
      HALF:    ld_data = XLEN'(shifted[15:0]);
      default: ld_data = shifted;
    endcase
    st_data = pipe_word_to_store << sh;
    st_mask = '0;
    for (int b = 0; b < 4; b++) st_mask[8*b +: 8] = {8{bmask[b]}};
  end

  logic st_hit, l2_ack, last, fill_done;
  logic [WW-1:0] word_nx;
  assign pipe_req_fulfilled = (state_q == COMPARE) && pipe_req_valid && hit;
  assign pipe_fetched_word  =
    (pipe_req_fulfilled && pipe_req_type == LOAD) ? ld_data : '0;
  assign st_hit  = pipe_req_fulfilled && pipe_req_type == STORE;
  assign l2_ack  = l2_valid_q && l2_req_fulfilled;
  assign last    = word_q == WW'(WPL - 1);
  assign word_nx = word_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    vway_d     = vway_q;
    mtag_d     = mtag_q;
    midx_d     = midx_q;
    l2_addr_d  = l2_addr_q;
    l2_type_d  = l2_type_q;
    l2_valid_d = l2_valid_q;
    l2_wdata_d = l2_wdata_q;
    fill_done  = 1'b0;
    unique case (state_q)
      COMPARE: begin
        if (pipe_req_valid && !hit) begin
          vway_d     = vsel;
          mtag_d     = req_tag;
          midx_d     = req_idx;
          word_d     = '0;
          l2_valid_d = 1'b1;
          if (vdirty) begin
            state_d    = WRITEBACK;
            l2_type_d  = STORE;
            l2_addr_d  = mk(tag_q[vsel][req_idx], req_idx, '0);
            l2_wdata_d = data_q[vsel][req_idx][0];
          end else begin
            state_d    = ALLOCATE;
            l2_type_d  = LOAD;
            l2_addr_d  = mk(req_tag, req_idx, '0);
            l2_wdata_d = '0;
          end
        end
      end
      WRITEBACK: begin
        if (l2_ack) begin
          if (last) begin
            state_d    = ALLOCATE;
            word_d     = '0;
            l2_type_d  = LOAD;
            l2_addr_d  = mk(mtag_q, midx_q, '0);
            l2_wdata_d = '0;
          end else begin
            word_d     = word_nx;
            l2_addr_d  = mk(tag_q[vway_q][midx_q], midx_q, word_nx);
            l2_wdata_d = data_q[vway_q][midx_q][word_nx];
          end
        end
      end
      ALLOCATE: begin
        if (l2_ack) begin
          if (last) begin
            fill_done  = 1'b1;
            state_d    = COMPARE;
            word_d     = '0;
            l2_valid_d = 1'b0;
          end else begin
            word_d    = word_nx;
            l2_addr_d = mk(mtag_q, midx_q, word_nx);
          end
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  logic            dwe;
  logic [VW-1:0]   dway;
  logic [SW-1:0]   dset;
  logic [WW-1:0]   dword;
  logic [XLEN-1:0] dval, dmask;
  always_comb begin
    dwe   = 1'b0;
    dway  = hway;
    dset  = req_idx;
    dword = req_wsel;
    dval  = st_data;
    dmask = st_mask;
    if (st_hit) begin
      dwe = 1'b1;
    end else if (state_q == ALLOCATE && l2_ack) begin
      dwe   = 1'b1;
      dway  = vway_q;
      dset  = midx_q;
      dword = word_q;
      dval  = l2_fetched_word;
      dmask = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (dwe) begin
      data_q[dway][dset][dword] <=
        (data_q[dway][dset][dword] & ~dmask) | (dval & dmask);
    end
    if (fill_done) tag_q[vway_q][midx_q] <= mtag_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      if (st_hit) dirty_q[req_idx][hway] <= 1'b1;
      if (fill_done) begin
        valid_q[midx_q][vway_q] <= 1'b1;
        dirty_q[midx_q][vway_q] <= 1'b0;
        vptr_q[midx_q] <= (WAYS > 1) ? vway_q + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= COMPARE;
      word_q     <= '0;
      vway_q     <= '0;
      mtag_q     <= '0;
      midx_q     <= '0;
      l2_addr_q  <= '0;
      l2_type_q  <= LOAD;
      l2_valid_q <= 1'b0;
      l2_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      vway_q     <= vway_d;
      mtag_q     <= mtag_d;
      midx_q     <= midx_d;
      l2_addr_q  <= l2_addr_d;
      l2_type_q  <= l2_type_d;
      l2_valid_q <= l2_valid_d;
      l2_wdata_q <= l2_wdata_d;
    end
  end

  assign l2_req_address   = l2_addr_q;
  assign l2_req_type      = l2_type_q;
  assign l2_req_valid     = l2_valid_q;
  assign l2_word_to_store = l2_wdata_q;
endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: scoreboard bench for dcache_assoc with an
// L2 model returning addr ^ 0x5A5A0000 and a configurable delay.
module tb_dcache_assoc;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] pipe_req_address = '0;
  memory_operation_size_e pipe_req_size = WORD;
  memory_operation_e pipe_req_type = LOAD;
  logic pipe_req_valid = 1'b0;
  logic [31:0] pipe_word_to_store = '0;
  logic [31:0] pipe_fetched_word;
  logic pipe_req_fulfilled;
  logic [31:0] l2_req_address;
  memory_operation_e l2_req_type;
  logic l2_req_valid;
  logic [31:0] l2_word_to_store;
  logic [31:0] l2_fetched_word = '0;
  logic l2_req_fulfilled = 1'b0;

  always #5 clk = ~clk;

  dcache_assoc dut (
    .clk(clk),
    .reset_n(reset_n),
    .pipe_req_address(pipe_req_address),
    .pipe_req_size(pipe_req_size),
    .pipe_req_type(pipe_req_type),
    .pipe_req_valid(pipe_req_valid),
    .pipe_word_to_store(pipe_word_to_store),
    .pipe_fetched_word(pipe_fetched_word),
    .pipe_req_fulfilled(pipe_req_fulfilled),
    .l2_req_address(l2_req_address),
    .l2_req_type(l2_req_type),
    .l2_req_valid(l2_req_valid),
    .l2_word_to_store(l2_word_to_store),
    .l2_fetched_word(l2_fetched_word),
    .l2_req_fulfilled(l2_req_fulfilled)
  );

  typedef struct packed {
    logic [31:0] a;
    logic        st;
    logic [31:0] d;
  } l2e_t;
  typedef struct packed {
    logic        st;
    logic [31:0] d;
  } pe_t;

  l2e_t l2q[$];
  pe_t  pq[$];
  int n_cmp = 0;
  int n_err = 0;
  int l2_cnt = 0;
  int l2_delay = 0;
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] l2rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A0000;
  endfunction

  // L2 model: pulses fulfilled l2_delay cycles after a request appears
  int wc = 0;
  logic [31:0] cap_a, cap_d;
  logic cap_t;
  l2e_t e;
  initial forever begin
    @(negedge clk);
    if (l2_req_fulfilled) begin
      l2_req_fulfilled = 1'b0;
      wc = 0;
    end else if (l2_req_valid) begin
      if (wc == 0) begin
        cap_a = l2_req_address;
        cap_t = (l2_req_type == STORE);
        cap_d = l2_word_to_store;
      end else begin
        check("l2_addr_stable", l2_req_address, cap_a);
        check("l2_type_stable", {31'b0, l2_req_type == STORE}, {31'b0, cap_t});
        check("l2_wdata_stable", l2_word_to_store, cap_d);
      end
      if (wc == l2_delay) begin
        l2_cnt++;
        if (l2q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL l2_unexpected: got %h want none", l2_req_address);
        end else begin
          e = l2q.pop_front();
          check("l2_addr", l2_req_address, e.a);
          check("l2_type", {31'b0, l2_req_type == STORE}, {31'b0, e.st});
          if (e.st) check("l2_wdata", l2_word_to_store, e.d);
        end
        if (l2_req_type == STORE) mem[l2_req_address] = l2_word_to_store;
        else l2_fetched_word = l2rd(l2_req_address);
        l2_req_fulfilled = 1'b1;
        wc = 0;
      end else begin
        wc++;
      end
    end else begin
      wc = 0;
    end
  end

  pe_t pe;
  initial forever begin
    @(negedge clk);
    if (pipe_req_fulfilled) begin
      if (pq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pipe_unexpected: got %h want none", pipe_fetched_word);
      end else begin
        pe = pq.pop_front();
        if (!pe.st) check("load_data", pipe_fetched_word, pe.d);
      end
    end
  end

  task automatic push_fill(input logic [31:0] line);
    for (int w = 0; w < 4; w++) l2q.push_back('{line + 32'(w * 4), 1'b0, 32'h0});
  endtask

  task automatic push_wb(input logic [31:0] a, input logic [31:0] d);
    l2q.push_back('{a, 1'b1, d});
  endtask

  task automatic req(input logic [31:0] a, input memory_operation_size_e sz,
                     input memory_operation_e t, input logic [31:0] wd,
                     input logic [31:0] exp, input int nl2, input bit hitexp);
    int base;
    int cyc;
    bit done;
    base = l2_cnt;
    cyc = 0;
    done = 1'b0;
    pq.push_back('{t == STORE, exp});
    pipe_req_address = a;
    pipe_req_size = sz;
    pipe_req_type = t;
    pipe_word_to_store = wd;
    pipe_req_valid = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (pipe_req_fulfilled) done = 1'b1;
      else cyc++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: got no fulfilled want fulfilled at %h", a);
    end
    if (hitexp) check("hit_latency", 32'(cyc), 32'd0);
    check("l2_count", 32'(l2_cnt - base), 32'(nl2));
    @(posedge clk);
    #1 pipe_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    pipe_req_valid = 1'b0;
    reset_n = 1'b0;
    l2q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int base;
    int cyc;
    #12;
    check("rst_fulfilled", {31'b0, pipe_req_fulfilled}, 32'd0);
    check("rst_fetched", pipe_fetched_word, 32'd0);
    check("rst_l2_valid", {31'b0, l2_req_valid}, 32'd0);
    check("rst_l2_addr", l2_req_address, 32'd0);
    check("rst_l2_type", {31'b0, l2_req_type == STORE}, 32'd0);
    check("rst_l2_wdata", l2_word_to_store, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    push_fill(32'h100);
    req(32'h100, WORD, LOAD, 0, 32'h5A5A0100, 4, 0);
    req(32'h10A, HALF, LOAD, 0, 32'h00005A5A, 0, 1);
    req(32'h101, BYTE, STORE, 32'hA5, 0, 0, 1);
    req(32'h100, WORD, LOAD, 0, 32'h5A5AA500, 0, 1);
    req(32'h103, BYTE, LOAD, 0, 32'h0000005A, 0, 1);

    do_reset();
    push_fill(32'h000);
    req(32'h000, WORD, LOAD, 0, 32'h5A5A0000, 4, 0);
    push_fill(32'h080);
    req(32'h080, WORD, LOAD, 0, 32'h5A5A0080, 4, 0);
    req(32'h000, WORD, LOAD, 0, 32'h5A5A0000, 0, 1);
    req(32'h080, WORD, LOAD, 0, 32'h5A5A0080, 0, 1);
    req(32'h000, WORD, STORE, 32'hDEADBEEF, 0, 0, 1);
    push_wb(32'h000, 32'hDEADBEEF);
    push_wb(32'h004, 32'h5A5A0004);
    push_wb(32'h008, 32'h5A5A0008);
    push_wb(32'h00C, 32'h5A5A000C);
    push_fill(32'h100);
    req(32'h100, WORD, LOAD, 0, 32'h5A5A0100, 8, 0);
    req(32'h080, WORD, LOAD, 0, 32'h5A5A0080, 0, 1);

    do_reset();
    push_fill(32'h200);
    base = l2_cnt;
    pipe_req_address = 32'h200;
    pipe_req_size = WORD;
    pipe_req_type = LOAD;
    pipe_req_valid = 1'b1;
    cyc = 0;
    while (l2_cnt < base + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_fill_words", 32'(l2_cnt - base), 32'd2);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("l2_valid_async_rst", {31'b0, l2_req_valid}, 32'd0);
    pipe_req_valid = 1'b0;
    l2q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    push_fill(32'h200);
    req(32'h200, WORD, LOAD, 0, 32'h5A5A0200, 4, 0);

    l2_delay = 3;
    push_fill(32'h1F0);
    req(32'h1F0, WORD, LOAD, 0, 32'h5A5A01F0, 4, 0);
    req(32'h1F2, HALF, STORE, 32'h0000BEEF, 0, 0, 1);
    req(32'h1F3, BYTE, LOAD, 0, 32'h000000BE, 0, 1);
    req(32'h1F0, HALF, LOAD, 0, 32'h000001F0, 0, 1);

    repeat (5) @(posedge clk);
    check("l2q_left", 32'(l2q.size()), 32'd0);
    check("pq_left", 32'(pq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised N-way set-associative, write-back, write-allocate L1 data cache. It is the successor to the direct-mapped load-only `dcache`, adding associativity, stores with byte/half/word masking, dirty tracking, and victim write-back. It sits between the pipeline memory stage and L2. Both sides use a request/fulfilled handshake with word-serial line transfers to L2.

## Interface
Parameters:
- LINE_SIZE, 16: bytes per line; power of two, ≥4.
- CACHE_SIZE, 256: total data bytes; power of two.
- WAYS, 2: associativity; power of two, ≥1. SETS = CACHE_SIZE/(LINE_SIZE*WAYS), which must be ≥1.
- XLEN, 32: address/data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- pipe_req_address  in  XLEN  byte address.
- pipe_req_size  in  memory_operation_size_e  BYTE/HALF/WORD.
- pipe_req_type  in  memory_operation_e  LOAD/STORE.
- pipe_req_valid  in  1  request present; held until the cycle after fulfilled.
- pipe_word_to_store  in  XLEN  store data, right-justified.
- pipe_fetched_word  out  XLEN  load data, zero-extended, right-justified.
- pipe_req_fulfilled  out  1  request completed this cycle.
- l2_req_address  out  XLEN  word-aligned L2 address.
- l2_req_type  out  memory_operation_e  LOAD (fill) / STORE (write-back).
- l2_req_valid  out  1  L2 request present.
- l2_word_to_store  out  XLEN  write-back data.
- l2_fetched_word  in  XLEN  fill data, valid with l2_req_fulfilled on LOAD.
- l2_req_fulfilled  in  1  L2 accepted/returned the current word.

## Operation
- Address split: offset = addr[log2(LINE_SIZE)-1:0]; index = next log2(SETS) bits; tag = the remainder. Word select = offset[.. :2].
- Alignment: HALF ignores addr[0]; WORD ignores addr[1:0]. There is no misalignment fault.
- Per line: valid, dirty, and tag. Per set: victim pointer, log2(WAYS) bits.
- FSM states COMPARE, WRITEBACK, ALLOCATE. Reset state is COMPARE.
- COMPARE, pipe_req_valid and hit:
  - pipe_req_fulfilled = 1 combinationally.
  - LOAD drives the selected byte/half/word, zero-extended.
  - STORE writes the masked lanes on that clock edge and sets dirty.
- COMPARE, miss:
  - Victim = lowest-index invalid way; otherwise the set's victim pointer.
  - Victim valid and dirty → WRITEBACK. Otherwise → ALLOCATE.
- WRITEBACK:
  - For w = 0..WORDS_PER_LINE-1, issue STORE of victim word w to {victim_tag, index, w, 2'b00}.
  - Advance w on each l2_req_fulfilled. After the last word → ALLOCATE.
- ALLOCATE:
  - For w = 0..WORDS_PER_LINE-1, issue LOAD of {req_tag, index, w, 2'b00}.
  - Write l2_fetched_word into word w on each l2_req_fulfilled.
  - After the last word: set valid, write tag, clear dirty, set victim pointer to (victim+1) mod WAYS, → COMPARE.
  - The re-presented request then hits.
- pipe_req_valid dropped mid-miss: the fill still completes; no fulfilled is issued.
- pipe_req_fulfilled is never asserted outside COMPARE.

## Timing
- Hit latency is 0 cycles; fulfilled is in the same cycle as the request.
- Clean miss: WORDS_PER_LINE L2 transactions, then 1 COMPARE cycle.
- Dirty miss: 2×WORDS_PER_LINE L2 transactions, then 1 cycle.
- l2_req_address, l2_req_type, l2_word_to_store are registered. They are stable while l2_req_valid is high and until l2_req_fulfilled.
- The next word's request is presented the cycle after fulfilled. l2_req_valid remains high between words of a line and drops in the cycle after the final fulfilled.
- l2_req_fulfilled while l2_req_valid is low is ignored.
- Reset values: all outputs 0, all valid/dirty bits 0, victim pointers 0, word counter 0.
- Reset asserted mid-miss: l2_req_valid falls asynchronously. All lines are invalidated and dirty data is discarded. State returns to COMPARE.

## Test plan
Defaults: 8 sets, index = addr[6:4]; L2 model returns mem[addr] = addr ^ 0x5A5A0000.
- Reset, then LOAD WORD 0x100 → 4 L2 LOADs at 0x100, 0x104, 0x108, 0x10C, then fulfilled with 0x5A5A0100. Then LOAD HALF 0x10A → fulfilled in the same cycle as the request, data 0x00005A5A, no l2_req_valid.
- STORE BYTE 0xA5 to 0x101 (hit), then LOAD WORD 0x100 → 0x5A5AA500; no L2 traffic.
- LOAD 0x000 and 0x080 (set 0, ways 0/1), then STORE WORD 0xDEADBEEF to 0x000, then LOAD 0x100 → 4 STOREs at 0x000..0x00C with first data 0xDEADBEEF, then 4 LOADs at 0x100; 0x080 still hits.
- After reset, LOAD 0x000 then 0x080 → no write-back; both then hit with 0 L2 traffic.
- Reset_n low after 2 fill words of 0x200 → l2_req_valid 0 at once. After release, LOAD 0x200 misses again with 4 fills.
- L2 delays each l2_req_fulfilled by 3 cycles → address/type held stable, exactly 4 requests, correct data returned.
